// File: rtl/roce_meta_pkg.sv
// RoCE command metadata layout shared by the meta arbiter and its users:
// field offsets inside the tx_meta word, the opcode encoding and a packing helper.
package roce_meta_pkg;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 3;
  localparam int QPN_LSB    = 3;
  localparam int QPN_W      = 24;
  localparam int LADDR_LSB  = 27;
  localparam int LADDR_W    = 48;
  localparam int RADDR_LSB  = 75;
  localparam int RADDR_W    = 48;
  localparam int LEN_LSB    = 123;
  localparam int LEN_W      = 32;
  localparam int META_FIELDS_W = LEN_LSB + LEN_W;

  typedef enum logic [OPCODE_W-1:0] {
    RDMA_READ  = 3'd0,
    RDMA_WRITE = 3'd1,
    RDMA_SEND  = 3'd2,
    RDMA_IMMED = 3'd3,
    RDMA_ACK   = 3'd4
  } roce_opcode_t;

  // Concatenation order mirrors the offsets above, len in the top bits.
  function automatic logic [META_FIELDS_W-1:0] pack_meta(
    input roce_opcode_t       op,
    input logic [QPN_W-1:0]   qpn,
    input logic [LADDR_W-1:0] laddr,
    input logic [RADDR_W-1:0] raddr,
    input logic [LEN_W-1:0]   len
  );
    pack_meta = {len, raddr, laddr, qpn, op};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the slot after the last winner;
// the pointer only moves when a grant is actually issued.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_en,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
  output logic [$clog2(NUM_REQ)-1:0] o_last_grant
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    w_idx    = r_last;
    w_found  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(r_last) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!w_found && i_req[cand_idx]) begin
        w_found = 1'b1;
        w_idx   = cand_idx;
      end
    end
  end

  assign o_grant      = (i_en && w_found) ? (NUM_REQ'(1) << w_idx) : '0;
  assign o_grant_idx  = w_idx;
  assign o_last_grant = r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= LAST_RST;
    end else if (i_en && w_found) begin
      r_last <= w_idx;
    end
  end

endmodule

// File: rtl/roce_meta_arbiter.sv
// Merges NUM_REQ RoCE meta streams into one command stream under a completion-credit
// limit. Optional per-requester grant counters with `define ROCE_META_ARB_STATS_EN.
module roce_meta_arbiter
  import roce_meta_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int META_W          = 256,
  parameter int STATUS_W        = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      ap_clk,
  input  logic                      areset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        s_axis_req_tvalid,
  output logic [NUM_REQ-1:0]        s_axis_req_tready,
  input  logic [NUM_REQ*META_W-1:0] s_axis_req_tdata,
  output logic                      m_axis_tx_meta_tvalid,
  input  logic                      m_axis_tx_meta_tready,
  output logic [META_W-1:0]         m_axis_tx_meta_tdata,
  output logic [META_W/8-1:0]       m_axis_tx_meta_tkeep,
  output logic                      m_axis_tx_meta_tlast,
  input  logic                      s_axis_tx_status_tvalid,
  output logic                      s_axis_tx_status_tready,
  input  logic [STATUS_W-1:0]       s_axis_tx_status_tdata,
  output logic [7:0]                outstanding,
  output logic                      idle,
  output logic                      credit_err
`ifdef ROCE_META_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [7:0] MAX_OS = 8'(MAX_OUTSTANDING);

  logic              r_out_vld;
  logic [META_W-1:0] r_out_data;
  logic [7:0]        r_outstanding;
  logic              r_credit_err;

  logic              w_cpl;
  logic              w_out_free;
  logic              w_credit_ok;
  logic              w_arb_en;
  logic              w_grant_any;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]  w_grant_idx;
  logic [IDX_W-1:0]  w_last_grant;
  logic              w_unused;

  assign w_cpl      = s_axis_tx_status_tvalid;
  assign w_out_free = !r_out_vld || m_axis_tx_meta_tready;
  // A completion in the same cycle returns its credit immediately, even at the limit.
  assign w_credit_ok = (r_outstanding < MAX_OS) || (w_cpl && (r_outstanding != 8'd0));
  assign w_arb_en    = !areset && enable && w_credit_ok && w_out_free;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .clk          (ap_clk),
    .rst          (areset),
    .i_req        (s_axis_req_tvalid),
    .i_en         (w_arb_en),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_last_grant (w_last_grant)
  );

  assign w_grant_any = |w_grant;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_out_vld     <= 1'b0;
      r_outstanding <= 8'd0;
      r_credit_err  <= 1'b0;
    end else begin
      if (w_grant_any) begin
        r_out_vld <= 1'b1;
      end else if (m_axis_tx_meta_tready) begin
        r_out_vld <= 1'b0;
      end
      if (w_grant_any && !w_cpl) begin
        r_outstanding <= r_outstanding + 8'd1;
      end else if (!w_grant_any && w_cpl) begin
        if (r_outstanding == 8'd0) begin
          r_credit_err <= 1'b1;
        end else begin
          r_outstanding <= r_outstanding - 8'd1;
        end
      end
    end
  end

  // Payload register carries no reset; r_out_vld qualifies it.
  always_ff @(posedge ap_clk) begin
    if (w_grant_any) begin
      r_out_data <= s_axis_req_tdata[int'(w_grant_idx)*META_W +: META_W];
    end
  end

`ifdef ROCE_META_ARB_STATS_EN
  logic [NUM_REQ*32-1:0] r_grant_cnt;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i]) begin
          r_grant_cnt[i*32 +: 32] <= r_grant_cnt[i*32 +: 32] + 32'd1;
        end
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

  assign s_axis_req_tready       = w_grant;
  assign m_axis_tx_meta_tvalid   = r_out_vld;
  assign m_axis_tx_meta_tdata    = r_out_data;
  assign m_axis_tx_meta_tkeep    = '1;
  assign m_axis_tx_meta_tlast    = 1'b1;
  assign s_axis_tx_status_tready = 1'b1;
  assign outstanding             = r_outstanding;
  assign credit_err              = r_credit_err;
  assign idle = (r_outstanding == 8'd0) && !r_out_vld && !(|s_axis_req_tvalid);

  // Completion payload and the arbiter pointer are not consumed here.
  assign w_unused = ^{s_axis_tx_status_tdata, w_last_grant};

endmodule

// File: doc/roce_meta_arbiter.md
ROCE_META_ARBITER -- requirements
Module: roce_meta_arbiter

Interface
REQ-001 SHALL take parameter NUM_REQ, default 2, as the number of requester meta streams (2..8).
REQ-002 SHALL take parameter META_W, default 256, as the tx_meta tdata width.
REQ-003 SHALL take parameter STATUS_W, default 512, as the tx_status tdata width.
REQ-004 SHALL take parameter MAX_OUTSTANDING, default 8, as the maximum issued-but-uncompleted commands (1..255).
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL have port ap_clk  in  1  the single clock.
REQ-007 SHALL have port areset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port enable  in  1  high permits new grants.
REQ-009 SHALL have port s_axis_req_tvalid  in  NUM_REQ  per-requester meta valid.
REQ-010 SHALL have port s_axis_req_tready  out  NUM_REQ  per-requester meta ready.
REQ-011 SHALL have port s_axis_req_tdata  in  NUM_REQ*META_W  requester i occupies bits [i*META_W +: META_W].
REQ-012 SHALL have ports m_axis_tx_meta_tvalid out 1, tready in 1, tdata out META_W, tkeep out META_W/8, tlast out 1, forming the merged command stream.
REQ-013 SHALL have ports s_axis_tx_status_tvalid in 1, tready out 1, tdata in STATUS_W, forming the completion stream.
REQ-014 SHALL have port outstanding  out  8  live count of commands in flight.
REQ-015 SHALL have port idle  out  1  high when outstanding==0, the output register is empty and no request is valid.
REQ-016 SHALL have port credit_err  out  1  sticky flag set on a completion received while outstanding==0.

Function
REQ-017 SHALL hold one output register; a grant is allowed in a cycle iff enable=1, at least one tvalid is high, outstanding<MAX_OUTSTANDING, and (output empty or m tvalid&tready).
REQ-018 SHALL choose round-robin: search starts at (last_grant+1) mod NUM_REQ; after reset last_grant=NUM_REQ-1, so requester 0 wins first.
REQ-019 SHALL assert exactly one s_axis_req_tready (the granted index) in a grant cycle, combinationally, and load that tdata unchanged into the output register; latency is 1 cycle from grant to m tvalid.
REQ-020 SHALL keep m_axis_tx_meta_tdata stable while tvalid=1 and tready=0.
REQ-021 SHALL drive m_axis_tx_meta_tkeep all-ones and tlast=1 constantly.
REQ-022 SHALL increment outstanding on a grant and decrement it on each s_axis_tx_status handshake; if both occur in the same cycle, outstanding SHALL be unchanged.
REQ-023 SHALL drive s_axis_tx_status_tready=1 constantly; a completion seen with outstanding==0 and no simultaneous grant SHALL leave outstanding at 0 and set credit_err.
REQ-024 SHALL NOT grant when outstanding==MAX_OUTSTANDING, except when a completion arrives in the same cycle (credit recycled same cycle).
REQ-025 SHALL let a registered command drain normally when enable falls; only new grants stop.
REQ-026 SHALL forward a command regardless of its opcode ([2:0]) or len ([154:123]), including len=0.

Reset
REQ-027 SHALL, on areset, clear m tvalid, all s tready, outstanding, and credit_err, set last_grant=NUM_REQ-1, and drop any registered command; areset mid-operation discards in-flight credits.
REQ-028 SHALL have idle=1 and tx_status tready=1 in the reset state.

Configuration
REQ-029 With ROCE_META_ARB_STATS_EN defined, SHALL add output grant_cnt (NUM_REQ*32): per-requester 32-bit wrapping grant counters, cleared by areset.
REQ-030 Without ROCE_META_ARB_STATS_EN, SHALL omit grant_cnt and all counter logic.

Structure
REQ-031 SHALL place the meta field offsets (opcode [2:0], QPN [26:3], lAddr [74:27], rAddr [122:75], len [154:123]) and the opcode enum (RDMA_READ=0, etc.) in package roce_meta_pkg.
REQ-032 SHALL implement arbitration in sub-module rr_arbiter (request vector, enable, one-hot grant, last_grant pointer).

Verification
REQ-033 Reset, then req0 and req1 valid continuously, tready=1, completions returned immediately -> grants alternate 0,1,0,1 with one beat per cycle.
REQ-034 MAX_OUTSTANDING=8, no completions -> exactly 8 commands issued, then all s tready=0; one completion -> exactly one more grant.
REQ-035 m tready held 0 for 5 cycles with a command loaded -> tdata stable, no further grants, outstanding=1.
REQ-036 Grant and completion in the same cycle at outstanding=3 -> outstanding remains 3.
REQ-037 Completion at outstanding=0 -> credit_err=1 sticky, outstanding=0; areset clears it.
REQ-038 enable dropped with a command registered -> command delivered once, then idle=1 after the final completion.
